// File: rtl/mult_err_monitor_pkg.sv
// Purpose: shared types and constants for the multiplier error monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, default counter/accumulator widths, ED width.
package mult_eval_pkg;

  localparam int CNT_W_DEF = 16;  // window length and sample/error counter width
  localparam int SUM_W_DEF = 32;  // error-distance accumulator width
  localparam int ED_W      = 16;  // width of exact product and |A*B - R|

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mult_err_monitor_if.sv
// Purpose: bundles the control, sample and result signals of the monitor.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the monitor gates acceptance of in_valid samples.
// Ports: master drives start/win_len/in_valid/A/B/R; slave drives in_ready,
//        busy, done and the four result counters.
interface mult_err_monitor_if #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 32
);
  logic             start;
  logic [CNT_W-1:0] win_len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       A;
  logic [7:0]       B;
  logic [15:0]      R;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_cnt;
  logic [SUM_W-1:0] sum_ed;
  logic [15:0]      max_ed;
  logic [CNT_W-1:0] smp_cnt;

  modport master (
    output start, win_len, in_valid, A, B, R,
    input  in_ready, busy, done, err_cnt, sum_ed, max_ed, smp_cnt
  );

  modport slave (
    input  start, win_len, in_valid, A, B, R,
    output in_ready, busy, done, err_cnt, sum_ed, max_ed, smp_cnt
  );
endinterface

// File: rtl/mult_err_monitor_ed_calc.sv
// Purpose: exact 8x8 product and unsigned error distance |A*B - R|.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b operands; r approximate product; prod exact product; ed distance.
module ed_calc
  import mult_eval_pkg::*;
(
  input  logic [7:0]      a,
  input  logic [7:0]      b,
  input  logic [15:0]     r,
  output logic [ED_W-1:0] prod,
  output logic [ED_W-1:0] ed
);

  always_comb begin
    prod = {8'd0, a} * {8'd0, b};
    // Subtract the smaller from the larger so the distance never wraps.
    ed   = (prod >= r) ? (prod - r) : (r - prod);
  end

endmodule

// File: rtl/mult_err_monitor.sv
// Purpose: measures error statistics of an approximate 8x8 multiplier over a window.
// Latency: results final and done pulsed 3 cycles after the last accepted sample.
// Backpressure: in_ready high only while the window is open (RUN); no internal stalls.
// Ports: clk, rst_n (async, active-low); bus = mult_err_monitor_if.slave carrying
//        start/win_len, the A/B/R sample handshake, busy/done and the results.
module mult_err_monitor
  import mult_eval_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  mult_err_monitor_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] win_len_q, win_len_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [SUM_W-1:0] sum_ed_q, sum_ed_d;
  logic [ED_W-1:0]  max_ed_q, max_ed_d;
  logic             drain_cnt_q, drain_cnt_d;

  // Stage 1: captured sample. Stage 2: error distance and error flag.
  logic             s1_vld_q, s1_vld_d;
  logic [7:0]       s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [15:0]      s1_r_q, s1_r_d;
  logic             s2_vld_q, s2_vld_d;
  logic [ED_W-1:0]  s2_ed_q, s2_ed_d;
  logic             s2_err_q, s2_err_d;

  logic [ED_W-1:0]  calc_prod, calc_ed;
  logic             accept;
  logic [CNT_W-1:0] smp_inc;
  logic [SUM_W:0]   sum_ext;

  ed_calc u_ed_calc (
    .a    (s1_a_q),
    .b    (s1_b_q),
    .r    (s1_r_q),
    .prod (calc_prod),
    .ed   (calc_ed)
  );

  always_comb begin
    state_d     = state_q;
    win_len_d   = win_len_q;
    smp_cnt_d   = smp_cnt_q;
    err_cnt_d   = err_cnt_q;
    sum_ed_d    = sum_ed_q;
    max_ed_d    = max_ed_q;
    drain_cnt_d = drain_cnt_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_r_d      = s1_r_q;
    s2_ed_d     = s2_ed_q;
    s2_err_d    = s2_err_q;

    accept  = bus.in_valid && (state_q == ST_RUN);
    smp_inc = smp_cnt_q + CNT_W'(1);
    sum_ext = {1'b0, sum_ed_q} + (SUM_W+1)'(s2_ed_q);

    // Stage 1
    s1_vld_d = accept;
    if (accept) begin
      s1_a_d = bus.A;
      s1_b_d = bus.B;
      s1_r_d = bus.R;
    end

    // Stage 2
    s2_vld_d = s1_vld_q;
    if (s1_vld_q) begin
      s2_ed_d  = calc_ed;
      s2_err_d = (calc_prod != s1_r_q);
    end

    // Stage 3: bubbles (s2_vld_q == 0) leave the accumulators untouched.
    if (s2_vld_q) begin
      sum_ed_d = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
      if (s2_err_q) err_cnt_d = err_cnt_q + CNT_W'(1);
      if (s2_ed_q > max_ed_q) max_ed_d = s2_ed_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          win_len_d   = bus.win_len;
          smp_cnt_d   = '0;
          err_cnt_d   = '0;
          sum_ed_d    = '0;
          max_ed_d    = '0;
          drain_cnt_d = 1'b0;
          // An empty window has nothing to collect and goes straight to drain.
          state_d     = (bus.win_len == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          smp_cnt_d = smp_inc;
          if (smp_inc == win_len_q) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = 1'b0;
          end
        end
      end
      ST_DRAIN: begin
        // Two cycles: lets the last sample cross stages 2 and 3.
        drain_cnt_d = 1'b1;
        if (drain_cnt_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      win_len_q   <= '0;
      smp_cnt_q   <= '0;
      err_cnt_q   <= '0;
      sum_ed_q    <= '0;
      max_ed_q    <= '0;
      drain_cnt_q <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_r_q      <= '0;
      s2_vld_q    <= 1'b0;
      s2_ed_q     <= '0;
      s2_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_len_q   <= win_len_d;
      smp_cnt_q   <= smp_cnt_d;
      err_cnt_q   <= err_cnt_d;
      sum_ed_q    <= sum_ed_d;
      max_ed_q    <= max_ed_d;
      drain_cnt_q <= drain_cnt_d;
      s1_vld_q    <= s1_vld_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_r_q      <= s1_r_d;
      s2_vld_q    <= s2_vld_d;
      s2_ed_q     <= s2_ed_d;
      s2_err_q    <= s2_err_d;
    end
  end

  assign bus.in_ready = (state_q == ST_RUN);
  assign bus.busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.err_cnt  = err_cnt_q;
  assign bus.sum_ed   = sum_ed_q;
  assign bus.max_ed   = max_ed_q;
  assign bus.smp_cnt  = smp_cnt_q;

endmodule

// File: tb/tb_mult_err_monitor.sv
// Purpose: self-checking bench for mult_err_monitor against a queue-based reference.
// Latency: expects done and final results 3 cycles after the last accepted sample.
// Backpressure: samples offered with random in_valid gaps while in_ready is high.
module tb_mult_err_monitor;

  localparam int CW  = 17;  // wide enough for a 65536-sample window
  localparam int SW  = 32;
  localparam int CW2 = 8;   // narrow instance used to reach sum saturation
  localparam int SW2 = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_err_monitor_if #(.CNT_W(CW),  .SUM_W(SW))  bus ();
  mult_err_monitor_if #(.CNT_W(CW2), .SUM_W(SW2)) bus2 ();

  mult_err_monitor #(.CNT_W(CW), .SUM_W(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mult_err_monitor #(.CNT_W(CW2), .SUM_W(SW2)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic [15:0] qr[$];
  int          exp_err;
  longint      exp_sum;
  int          exp_max;

  // Reference: statistics straight from the definition of error distance.
  function automatic void ref_model(input longint sat);
    exp_err = 0;
    exp_sum = 0;
    exp_max = 0;
    foreach (qa[i]) begin
      int p;
      int d;
      p = int'(qa[i]) * int'(qb[i]);
      d = p - int'(qr[i]);
      if (d < 0) d = -d;
      if (d != 0) exp_err++;
      exp_sum += d;
      if (exp_sum > sat) exp_sum = sat;
      if (d > exp_max) exp_max = d;
    end
  endfunction

  function automatic int approx_r(input int a, input int b);
    int p;
    p = a * b;
    case ($urandom_range(3))
      0:       return p;
      1:       return (p ^ int'($urandom_range(15))) & 16'hFFFF;
      2:       return int'($urandom_range(65535));
      default: return p & 16'hFF00;
    endcase
  endfunction

  task automatic push(input int a, input int b, input int r);
    qa.push_back(8'(a));
    qb.push_back(8'(b));
    qr.push_back(16'(r));
  endtask

  task automatic clear_q();
    qa.delete();
    qb.delete();
    qr.delete();
  endtask

  function automatic logic [2:0] st();
    return {bus.in_ready, bus.busy, bus.done};
  endfunction

  // Runs one window on the main instance using the queued samples.
  // poke >= 0 raises start (win_len=1) while offering sample index poke.
  task automatic run_window(input int wl, input int gap, input int poke, input string nm);
    int   idx;
    int   cyc;
    logic rdy_bad;
    logic poked;
    ref_model(64'h0000_0000_FFFF_FFFF);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.win_len  = CW'(wl);
    bus.in_valid = 1'b0;
    idx = 0;
    cyc = 0;
    rdy_bad = 1'b0;
    poked = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    while (idx < wl && cyc < wl * 8 + 100) begin
      if (bus.in_ready !== 1'b1) rdy_bad = 1'b1;
      bus.start = 1'b0;
      if (!poked && idx == poke) begin
        bus.start   = 1'b1;
        bus.win_len = CW'(1);
        poked       = 1'b1;
      end
      if (int'($urandom_range(99)) >= gap) begin
        bus.in_valid = 1'b1;
        bus.A = qa[idx];
        bus.B = qb[idx];
        bus.R = qr[idx];
        idx++;
      end else begin
        bus.in_valid = 1'b0;
        bus.A = 8'($urandom);
        bus.B = 8'($urandom);
        bus.R = 16'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    n_cmp++;
    if (idx != wl) begin
      n_fail++;
      $display("FAIL %s timeout: accepted %0d samples, required %0d", nm, idx, wl);
    end
    n_cmp++;
    if (rdy_bad) begin
      n_fail++;
      $display("FAIL %s in_ready: got 0 during open window, required 1", nm);
    end
    n_cmp++;
    if (st() !== 3'b010) begin
      n_fail++;
      $display("FAIL %s drain1 {rdy,busy,done}: got %b required 010", nm, st());
    end
    @(negedge clk);
    n_cmp++;
    if (st() !== 3'b010) begin
      n_fail++;
      $display("FAIL %s drain2 {rdy,busy,done}: got %b required 010", nm, st());
    end
    @(negedge clk);
    n_cmp++;
    if (st() !== 3'b001) begin
      n_fail++;
      $display("FAIL %s done {rdy,busy,done}: got %b required 001", nm, st());
    end
    n_cmp++;
    if (bus.err_cnt !== CW'(exp_err)) begin
      n_fail++;
      $display("FAIL %s err_cnt: got %0d required %0d", nm, bus.err_cnt, exp_err);
    end
    n_cmp++;
    if (bus.sum_ed !== exp_sum[31:0]) begin
      n_fail++;
      $display("FAIL %s sum_ed: got %0d required %0d", nm, bus.sum_ed, exp_sum);
    end
    n_cmp++;
    if (bus.max_ed !== 16'(exp_max)) begin
      n_fail++;
      $display("FAIL %s max_ed: got %0d required %0d", nm, bus.max_ed, exp_max);
    end
    n_cmp++;
    if (bus.smp_cnt !== CW'(wl)) begin
      n_fail++;
      $display("FAIL %s smp_cnt: got %0d required %0d", nm, bus.smp_cnt, wl);
    end
    @(negedge clk);
    n_cmp++;
    if (st() !== 3'b000) begin
      n_fail++;
      $display("FAIL %s idle {rdy,busy,done}: got %b required 000", nm, st());
    end
    n_cmp++;
    if (bus.sum_ed !== exp_sum[31:0] || bus.smp_cnt !== CW'(wl)) begin
      n_fail++;
      $display("FAIL %s hold: got sum %0d smp %0d required %0d %0d",
               nm, bus.sum_ed, bus.smp_cnt, exp_sum, wl);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.in_ready, bus.busy, bus.done, bus.err_cnt, bus.sum_ed, bus.max_ed, bus.smp_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy%b busy%b done%b err%0d sum%0d max%0d smp%0d required all 0",
               bus.in_ready, bus.busy, bus.done, bus.err_cnt, bus.sum_ed, bus.max_ed, bus.smp_cnt);
    end
    n_cmp++;
    if ({bus2.in_ready, bus2.busy, bus2.done, bus2.err_cnt, bus2.sum_ed, bus2.max_ed, bus2.smp_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_sat: got nonzero output, required all 0");
    end
    // Release reset with start already high: the first edge must take it.
    bus.start   = 1'b1;
    bus.win_len = '0;
    rst_n       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_start busy: got %b required 1", bus.busy);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_vectors();
    clear_q(); push(15, 15, 224);
    run_window(1, 0, -1, "single");
    clear_q(); push(255, 255, 65025); push(16, 16, 256); push(0, 9, 0);
    run_window(3, 30, -1, "exact");
    clear_q(); push(10, 10, 104); push(200, 3, 590);
    run_window(2, 50, -1, "gaps");
    clear_q();
    run_window(0, 0, -1, "empty");
  endtask

  task automatic test_random();
    for (int w = 0; w < 6; w++) begin
      int wl;
      wl = int'($urandom_range(24, 1));
      clear_q();
      for (int k = 0; k < wl; k++) begin
        int a;
        int b;
        a = int'($urandom_range(255));
        b = int'($urandom_range(255));
        push(a, b, approx_r(a, b));
      end
      run_window(wl, 40, -1, "random");
    end
  endtask

  task automatic test_start_ignored();
    clear_q();
    for (int k = 0; k < 4; k++) push(k + 20, 7, 0);
    run_window(4, 20, 2, "start_in_run");
  endtask

  // A start raised in the DONE cycle must open a new window immediately.
  task automatic test_back_to_back();
    clear_q();
    run_window(0, 0, -1, "b2b_first");
    @(negedge clk);
    bus.start = 1'b1; bus.win_len = '0;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_setup done: got %b required 1", bus.done);
    end
    bus.start = 1'b1; bus.win_len = CW'(2);
    @(negedge clk);
    bus.start = 1'b0;
    n_cmp++;
    if (st() !== 3'b110) begin
      n_fail++;
      $display("FAIL b2b_restart {rdy,busy,done}: got %b required 110", st());
    end
    bus.in_valid = 1'b1; bus.A = 8'd3; bus.B = 8'd4; bus.R = 16'd12;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bus.smp_cnt !== CW'(2) || bus.err_cnt !== '0) begin
      n_fail++;
      $display("FAIL b2b_results: got smp %0d err %0d required 2 0", bus.smp_cnt, bus.err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic done_seen;
    @(negedge clk);
    bus.start = 1'b1; bus.win_len = CW'(5);
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1; bus.A = 8'd9; bus.B = 8'd9; bus.R = 16'd0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.in_ready, bus.busy, bus.done, bus.err_cnt, bus.sum_ed, bus.max_ed, bus.smp_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid async: got busy%b err%0d sum%0d smp%0d required all 0",
               bus.busy, bus.err_cnt, bus.sum_ed, bus.smp_cnt);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen = 1'b1;
    end
    n_cmp++;
    if (done_seen) begin
      n_fail++;
      $display("FAIL reset_mid no_done: got done/busy activity after release, required none");
    end
    n_cmp++;
    if ({bus.err_cnt, bus.sum_ed, bus.max_ed, bus.smp_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid results: got err%0d sum%0d max%0d smp%0d required 0",
               bus.err_cnt, bus.sum_ed, bus.max_ed, bus.smp_cnt);
    end
  endtask

  task automatic test_saturation();
    int wait_cyc;
    clear_q(); push(255, 255, 0); push(255, 255, 1);
    ref_model(64'd65535);
    @(negedge clk);
    bus2.start = 1'b1; bus2.win_len = CW2'(2);
    @(negedge clk);
    bus2.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus2.in_valid = 1'b1; bus2.A = qa[k]; bus2.B = qb[k]; bus2.R = qr[k];
      @(negedge clk);
    end
    bus2.in_valid = 1'b0;
    wait_cyc = 0;
    while (bus2.done !== 1'b1 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    n_cmp++;
    if (bus2.done !== 1'b1) begin
      n_fail++;
      $display("FAIL sat done: got %b required 1 within 10 cycles", bus2.done);
    end
    n_cmp++;
    if (bus2.sum_ed !== exp_sum[15:0]) begin
      n_fail++;
      $display("FAIL sat sum_ed: got %0d required %0d", bus2.sum_ed, exp_sum);
    end
    n_cmp++;
    if (bus2.err_cnt !== CW2'(exp_err) || bus2.max_ed !== 16'(exp_max)) begin
      n_fail++;
      $display("FAIL sat err/max: got %0d/%0d required %0d/%0d",
               bus2.err_cnt, bus2.max_ed, exp_err, exp_max);
    end
  endtask

  task automatic test_exhaustive();
    clear_q();
    for (int i = 0; i < 65536; i++) begin
      push(i >> 8, i & 255, approx_r(i >> 8, i & 255));
    end
    run_window(65536, 0, -1, "exhaustive");
  endtask

  initial begin
    bus.start = 1'b0;  bus.win_len = '0;  bus.in_valid = 1'b0;
    bus.A = '0;  bus.B = '0;  bus.R = '0;
    bus2.start = 1'b0; bus2.win_len = '0; bus2.in_valid = 1'b0;
    bus2.A = '0; bus2.B = '0; bus2.R = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_vectors();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_err_monitor.md
MULT_ERR_MONITOR -- requirements
Module: mult_err_monitor

Interface
REQ-001 Parameter: CNT_W, 16, width of window length and sample/error counters.
REQ-002 Parameter: SUM_W, 32, width of the error-distance accumulator.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to open a measurement window.
REQ-006 win_len  input  CNT_W  number of samples in the window, sampled when start is accepted.
REQ-007 in_valid  input  1  sample present on A/B/R.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 A  input  8  multiplicand fed to the 8x8 approximate multiplier.
REQ-010 B  input  8  multiplier operand.
REQ-011 R  input  16  approximate product returned by the multiplier for A, B.
REQ-012 busy  output  1  window open or draining.
REQ-013 done  output  1  one-cycle pulse: results final.
REQ-014 err_cnt  output  CNT_W  samples with R != A*B.
REQ-015 sum_ed  output  SUM_W  sum of |A*B - R| over window.
REQ-016 max_ed  output  16  largest |A*B - R| in window.
REQ-017 smp_cnt  output  CNT_W  samples accepted in window.

Function
REQ-018 States IDLE, RUN, DRAIN, DONE; encoding from shared package.
REQ-019 IDLE/DONE + start=1 -> RUN; win_len latched; err_cnt, sum_ed, max_ed, smp_cnt cleared same edge.
REQ-020 start with win_len=0 -> DRAIN directly; done follows with all results zero.
REQ-021 start while busy=1 ignored; no state or result change.
REQ-022 in_ready = 1 iff state==RUN; sample accepted on in_valid && in_ready.
REQ-023 Accept increments smp_cnt; accept making smp_cnt == latched win_len moves RUN -> DRAIN on that edge.
REQ-024 Pipeline: stage 1 registers A, B, R on accept; stage 2 registers exact product (unsigned 16-bit A*B) and ED = |A*B - R|; stage 3 updates accumulators.
REQ-025 ED unsigned 16-bit; R > A*B handled by swapping operands, never wrap.
REQ-026 Stage 3: sum_ed += ED; err_cnt += (ED != 0); max_ed = max(max_ed, ED).
REQ-027 sum_ed saturates at all-ones; no wrap.
REQ-028 DRAIN lasts exactly 2 cycles, then DONE; done=1 only during first DONE cycle (last accept edge + 3 cycles).
REQ-029 Results hold unchanged in DONE and IDLE until next accepted start; DONE -> IDLE after one cycle if no start.
REQ-030 busy = 1 in RUN and DRAIN, 0 otherwise.
REQ-031 Stall (in_valid=0 in RUN) inserts bubbles; bubbles never change accumulators.

Reset
REQ-032 rst_n=0 asynchronously forces IDLE, pipeline valid bits 0, all outputs 0 (in_ready, busy, done, err_cnt, sum_ed, max_ed, smp_cnt).
REQ-033 Reset mid-window discards the window; no done pulse after release.
REQ-034 First start accepted on first rising edge with rst_n=1.

Structure
REQ-035 Package mult_eval_pkg holds state enum, CNT_W/SUM_W defaults, and ED width constant.
REQ-036 One sub-module ed_calc (combinational: A, B, R -> exact product, ED) instantiated in stage 2.
REQ-037 No multiplier instance inside; R supplied externally by the approximate multiplier stage.

Verification
REQ-038 win_len=1, A=15, B=15, R=224 -> done at accept+3, err_cnt=1, sum_ed=1, max_ed=1, smp_cnt=1.
REQ-039 win_len=3, samples (255,255,65025),(16,16,256),(0,9,0) -> err_cnt=0, sum_ed=0, max_ed=0.
REQ-040 win_len=2, samples (10,10,104),(200,3,590) with in_valid gaps -> err_cnt=2, sum_ed=14, max_ed=10.
REQ-041 win_len=0 -> busy 2 cycles, done pulse, all results 0; in_ready never 1.
REQ-042 start during RUN and rst_n pulse mid-window -> start ignored; after reset all outputs 0, no done.
REQ-043 Exhaustive 65536-sample window against golden ED model -> sum_ed/err_cnt/max_ed match, no saturation.
